// File: rtl/q2_clock_seq.sv
// Run/stop machine-cycle sequencer: a programmable prescaler drives a one-hot phase ring.
// An end-of-cycle strobe goes to sc or ws. Stop and step finish the current machine cycle before going idle.
module q2_clock_seq #(
  parameter int DIV_W  = 8,
  parameter int PHASES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic [DIV_W-1:0]  div,
  input  logic              cdiv,
  output logic              tick,
  output logic [PHASES-1:0] phase,
  output logic              sc,
  output logic              ws,
  output logic              running
);

  localparam int IDX_W = (PHASES > 2) ? $clog2(PHASES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PHASES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    STEP = 2'd3
  } state_t;

  state_t           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] idx_q;

  logic [DIV_W-1:0] cnt_d;
  logic [IDX_W-1:0] idx_d;
  logic             active;
  logic             last_idx;
  logic             eoc;

  assign active   = (state_q != IDLE);
  assign tick     = active && (cnt_q == div_q);
  assign last_idx = (idx_q == LAST_IDX);
  assign eoc      = tick && last_idx;
  assign sc       = eoc && cdiv;
  assign ws       = eoc && !cdiv;
  assign running  = active;

  // cnt_q never passes div_q because div_q only reloads together with cnt_q clearing.
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign idx_d = !tick ? idx_q : (last_idx ? '0 : idx_q + 1'b1);

  generate
    for (genvar gi = 0; gi < PHASES; gi++) begin : g_phase
      assign phase[gi] = active && (idx_q == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      div_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!stop && (start || step)) begin
            state_q <= start ? RUN : STEP;
            cnt_q   <= '0;
            idx_q   <= '0;
            div_q   <= div;
          end
        end
        RUN: begin
          cnt_q <= cnt_d;
          idx_q <= idx_d;
          if (tick) div_q <= div;
          if (stop) state_q <= HALT;
        end
        HALT, STEP: begin
          // A finishing cycle wraps cnt/idx back to zero on its own at eoc.
          cnt_q <= cnt_d;
          idx_q <= idx_d;
          if (tick) div_q <= div;
          if (start)    state_q <= RUN;
          else if (eoc) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q2_clock_seq.sv
// Bench for q2_clock_seq: directed scenarios plus random pulses, all checked per clk against a phase-length model.
module tb_q2_clock_seq;
  localparam int DIV_W  = 8;
  localparam int PHASES = 4;

  logic              clk = 1'b0;
  logic              rst, start, stop, step, cdiv;
  logic [DIV_W-1:0]  div;
  logic              tick, sc, ws, running;
  logic [PHASES-1:0] phase;

  q2_clock_seq #(.DIV_W(DIV_W), .PHASES(PHASES)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
    .div(div), .cdiv(cdiv), .tick(tick), .phase(phase),
    .sc(sc), .ws(ws), .running(running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0=idle 1=run 2=halt 3=step; a phase lasts m_len clks, m_el clks have elapsed.
  int m_mode, m_ph, m_el, m_len;
  int run_cnt, ws_cnt, sc_cnt;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ph = 0; m_el = 0; m_len = 1;
  endtask

  task automatic clear_counts();
    run_cnt = 0; ws_cnt = 0; sc_cnt = 0;
  endtask

  // One clk: drive inputs, check outputs against the model, then advance the model at the edge.
  task automatic cyc(input logic st, input logic sp, input logic sep, input logic r);
    bit et, eeoc, phase_done;
    int new_len;
    start = st; stop = sp; step = sep; rst = r;
    #1;
    et   = (m_mode != 0) && (m_el == m_len - 1);
    eeoc = et && (m_ph == PHASES - 1);
    check("tick",    tick,    et);
    check("phase",   phase,   (m_mode != 0) ? (1 << m_ph) : 0);
    check("sc",      sc,      eeoc && cdiv);
    check("ws",      ws,      eeoc && !cdiv);
    check("running", running, m_mode != 0);
    if (running) run_cnt++;
    if (ws) ws_cnt++;
    if (sc) sc_cnt++;
    new_len = int'(div) + 1;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (m_mode == 0) begin
      if (!sp && (st || sep)) begin
        m_mode = st ? 1 : 3;
        m_ph = 0; m_el = 0; m_len = new_len;
      end
    end else begin
      phase_done = et;
      case (m_mode)
        1: if (sp) m_mode = 2;
        default: if (st) m_mode = 1; else if (eeoc) m_mode = 0;
      endcase
      if (phase_done) begin
        m_el = 0; m_len = new_len; m_ph = (m_ph + 1) % PHASES;
      end else begin
        m_el++;
      end
    end
    @(negedge clk);
    start = 1'b0; stop = 1'b0; step = 1'b0;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  // Run until the model reaches the wanted running phase, bounded.
  task automatic wait_phase(input int ph, input string tag);
    int guard = 0;
    while (!(m_mode == 1 && m_ph == ph) && guard < 200) begin
      cyc(0, 0, 0, 0);
      guard++;
    end
    check(tag, guard < 200, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; div = '0; cdiv = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    clear_counts();
    cyc(0, 0, 0, 1);
    idle_n(2);
    $display("reset: running=%0b phase=%b", running, phase);

    // div=0, sc routing, free running then stop
    div = 0; cdiv = 1;
    clear_counts();
    cyc(1, 0, 0, 0);
    idle_n(12);
    check("run_sc_count", sc_cnt, 3);
    check("run_ws_count", ws_cnt, 0);
    cyc(0, 1, 0, 0);
    idle_n(6);
    $display("div0 run: sc pulses=%0d", sc_cnt);

    // div=2, change div mid-phase
    div = 2;
    cyc(1, 0, 0, 0);
    idle_n(13);
    cyc(0, 0, 0, 0);
    div = 0;
    idle_n(10);
    cyc(0, 1, 0, 0);
    idle_n(8);
    $display("div2 run with mid-phase div change done");

    // stop during 0010, start during HALT, stop again
    div = 1;
    cyc(1, 0, 0, 0);
    wait_phase(1, "wait_ph1");
    cyc(0, 1, 0, 0);
    idle_n(2);
    cyc(1, 0, 0, 0);
    idle_n(10);
    check("halt_cancel", running, 1);
    wait_phase(1, "wait_ph1b");
    cyc(0, 1, 0, 0);
    idle_n(10);
    check("halt_done", running, 0);
    $display("halt scenario done");

    // single step, ws routing
    div = 1; cdiv = 0;
    clear_counts();
    cyc(0, 0, 1, 0);
    idle_n(12);
    check("step_len", run_cnt, 8);
    check("step_ws", ws_cnt, 1);
    check("step_sc", sc_cnt, 0);
    cyc(0, 0, 1, 0);
    idle_n(3);
    cyc(1, 0, 0, 0);
    idle_n(12);
    check("step_to_run", running, 1);
    cyc(0, 1, 0, 0);
    idle_n(10);
    $display("step: running clks=%0d ws=%0d", run_cnt, ws_cnt);

    // simultaneous pulses in IDLE
    cyc(1, 1, 0, 0);
    idle_n(2);
    check("start_stop_idle", running, 0);
    cyc(0, 1, 1, 0);
    idle_n(2);
    check("step_stop_idle", running, 0);
    cyc(1, 0, 1, 0);
    idle_n(12);
    check("start_step_run", running, 1);
    $display("simultaneous pulses done");

    // reset in phase 0100, then restart from 0001
    wait_phase(2, "wait_ph2");
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 0);
    check("restart_phase", phase, 1);
    idle_n(4);
    cyc(0, 1, 0, 0);
    idle_n(10);
    $display("mid-run reset done");

    // maximum div: one stepped cycle is 4*256 clks
    div = '1; cdiv = 1;
    clear_counts();
    cyc(0, 0, 1, 0);
    idle_n(1030);
    check("maxdiv_len", run_cnt, PHASES * (1 << DIV_W));
    check("maxdiv_sc", sc_cnt, 1);
    $display("max div step: running clks=%0d", run_cnt);

    // random control pulses
    for (int i = 0; i < 600; i++) begin
      div  = DIV_W'($urandom_range(0, 3));
      cdiv = 1'($urandom_range(0, 1));
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 14) == 0),
          ($urandom_range(0, 14) == 0), ($urandom_range(0, 99) == 0));
    end
    $display("random: 600 clks done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
